// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one inverse round per cycle, inverse key schedule on the fly,
// with an optional cache of the last expanded round-10 key.
module aes_inv_cipher_iter #(
  parameter int unsigned KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         ready,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StExpand, StRound} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128, which is the multiplicative inverse (0 maps to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned k);
    logic [15:0] d;
    d = {a, a} << k;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  // Byte 4c+r sits at row r, column c; InvShiftRows rotates row r right by r.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b) ^
                                gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
      end
    end
    return o;
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] data_q, data_d;
  logic [127:0] ct_q, ct_d;
  logic [127:0] key_q, key_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] rk10_q, rk10_d;
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] pt_q, pt_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;

  logic [127:0] next_rkey, prev_rkey, round_t;
  logic         cache_hit;

  assign next_rkey = fwd_expand(rkey_q, rcon(cnt_q));
  assign prev_rkey = inv_expand(rkey_q, rcon(cnt_q));
  assign round_t   = inv_sub_shift(data_q) ^ prev_rkey;
  assign cache_hit = (KEY_CACHE != 0) && cache_vld_q && (key == cache_key_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rkey_d      = rkey_q;
    data_d      = data_q;
    ct_d        = ct_q;
    key_d       = key_q;
    cache_key_d = cache_key_q;
    rk10_d      = rk10_q;
    cache_vld_d = cache_vld_q;
    pt_d        = pt_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ct_d    = ciphertext;
          key_d   = key;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (cache_hit) begin
            data_d  = ciphertext ^ rk10_q;
            rkey_d  = rk10_q;
            cnt_d   = 4'd10;
            state_d = StRound;
          end else begin
            rkey_d  = key;
            cnt_d   = 4'd1;
            state_d = StExpand;
          end
        end
      end
      StExpand: begin
        rkey_d = next_rkey;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          data_d      = ct_q ^ next_rkey;
          rk10_d      = next_rkey;
          cache_key_d = key_q;
          cache_vld_d = 1'b1;
          cnt_d       = 4'd10;
          state_d     = StRound;
        end
      end
      StRound: begin
        rkey_d = prev_rkey;
        cnt_d  = cnt_q - 4'd1;
        data_d = (cnt_q == 4'd1) ? round_t : inv_mix(round_t);
        if (cnt_q == 4'd1) begin
          pt_d    = round_t;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rkey_q      <= '0;
      data_q      <= '0;
      ct_q        <= '0;
      key_q       <= '0;
      cache_key_q <= '0;
      rk10_q      <= '0;
      cache_vld_q <= 1'b0;
      pt_q        <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rkey_q      <= rkey_d;
      data_q      <= data_d;
      ct_q        <= ct_d;
      key_q       <= key_d;
      cache_key_q <= cache_key_d;
      rk10_q      <= rk10_d;
      cache_vld_q <= cache_vld_d;
      pt_q        <= pt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign plaintext = pt_q;
  assign ready     = ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors, cache/latency behaviour, reset and a
// byte-array AES reference model for randomized round trips.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [127:0] ciphertext, key;
  logic [127:0] pt_c, pt_n;
  logic         ready_c, ready_n, busy_c, busy_n;

  aes_inv_cipher_iter #(.KEY_CACHE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .ciphertext(ciphertext), .key(key),
    .plaintext(pt_c), .ready(ready_c), .busy(busy_c)
  );

  aes_inv_cipher_iter #(.KEY_CACHE(0)) u_dut_nc (
    .clk(clk), .reset(reset), .start(start), .ciphertext(ciphertext), .key(key),
    .plaintext(pt_n), .ready(ready_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  sbox_m  [256];
  logic [7:0]  isbox_m [256];
  logic [31:0] w_m     [44];

  task automatic init_tables;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_m[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_m[sbox_m[i]] = 8'(i);
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w_m[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w_m[i-1];
      if (i % 4 == 0) begin
        t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h0};
        rc = m_mul(rc, 8'h02);
      end
      w_m[i] = w_m[i-4] ^ t;
    end
  endtask

  function automatic logic [7:0] rkb(input int rnd, input int i);
    return w_m[4*rnd + i/4][31-8*(i%4) -: 8];
  endfunction

  function automatic logic [127:0] m_encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkb(0, i);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = m_mul(t[r], 8'h02) ^ m_mul(t[(r+1)%4], 8'h03) ^ t[(r+2)%4] ^ t[(r+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkb(rnd, i);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] m_decrypt(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rkb(10, i);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+4-r)%4)+r];
      for (int i = 0; i < 16; i++) s[i] = isbox_m[t[i]] ^ rkb(rnd, i);
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = m_mul(t[r], 8'h0e) ^ m_mul(t[(r+1)%4], 8'h0b) ^
                       m_mul(t[(r+2)%4], 8'h0d) ^ m_mul(t[(r+3)%4], 8'h09);
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  // Latency counts clock edges from (and including) the accepting edge until ready is seen.
  task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] k,
                        input int exp_lat, input bit hammer, input logic [127:0] exp_pt);
    logic [127:0] prev_c;
    int lat, lat_c, lat_n, busy_cnt;
    bit done_c, done_n;
    prev_c = pt_c;
    lat = 0; lat_c = 0; lat_n = 0; busy_cnt = 0;
    done_c = 0; done_n = 0;
    @(negedge clk);
    ciphertext = ct;
    key        = k;
    start      = 1'b1;
    while (!(done_c && done_n) && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        check_eq({tag, " ready_drop"}, ready_c, 0);
        check_eq({tag, " pt_hold"}, pt_c, prev_c);
      end
      if (busy_c) busy_cnt++;
      if (ready_c && !done_c) begin done_c = 1; lat_c = lat; end
      if (ready_n && !done_n) begin done_n = 1; lat_n = lat; end
      if (hammer && !done_c) begin
        start      = 1'b1;
        ciphertext = rand128();
        key        = rand128();
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, " lat"}, lat_c, exp_lat);
    check_eq({tag, " lat_nocache"}, lat_n, 21);
    check_eq({tag, " busy_cycles"}, busy_cnt, exp_lat - 1);
    check_eq({tag, " pt"}, pt_c, exp_pt);
    check_eq({tag, " pt_nocache"}, pt_n, exp_pt);
    check_eq({tag, " busy_after"}, busy_c, 0);
    @(negedge clk);
    check_eq({tag, " pt_stable"}, pt_c, exp_pt);
    check_eq({tag, " ready_level"}, ready_c, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " pt"}, pt_c, 0);
    check_eq({tag, " ready"}, ready_c, 0);
    check_eq({tag, " busy"}, busy_c, 0);
    check_eq({tag, " pt_nocache"}, pt_n, 0);
  endtask

  task automatic pulse_reset_after(input int edges, input logic [127:0] k);
    @(negedge clk);
    ciphertext = rand128();
    key        = k;
    start      = 1'b1;
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Pt1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] Key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Pt2  = 128'h3243f6a8885a308d313198a2e0370734;

  initial begin
    logic [127:0] k, p, c, last_k;
    int exp_lat;
    init_tables();
    reset = 1'b1; start = 1'b0; ciphertext = '0; key = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    run_op("fips_c1", Ct1, Key1, 21, 1'b0, Pt1);
    check_eq("fips_c1 rk10", u_dut.rk10_q, Rk10);
    run_op("fips_b", Ct2, Key2, 21, 1'b0, Pt2);

    expand_key(Key2);
    p = rand128();
    c = m_encrypt(p);
    run_op("cache_hit", c, Key2, 11, 1'b0, p);

    k = rand128();
    expand_key(k);
    p = rand128();
    run_op("hammer", m_encrypt(p), k, 21, 1'b1, p);

    // Reset in ROUND r=5 on a cache hit; the rerun must expand again.
    run_op("pre_reset", Ct1, Key1, 21, 1'b0, Pt1);
    pulse_reset_after(6, Key1);
    check_reset_outputs("reset_round");
    run_op("after_reset", Ct1, Key1, 21, 1'b0, Pt1);

    // Reset mid-expansion must not leave that key cached.
    pulse_reset_after(5, Key2);
    check_reset_outputs("reset_expand");
    run_op("after_expand_reset", Ct2, Key2, 21, 1'b0, Pt2);

    last_k = Key2;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(3) == 0) begin
        k = last_k;
        exp_lat = 11;
      end else begin
        k = rand128();
        exp_lat = (k == last_k) ? 11 : 21;
      end
      expand_key(k);
      p = rand128();
      run_op("roundtrip", m_encrypt(p), k, exp_lat, 1'b0, p);
      last_k = k;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
